// File: rtl/core_scheduler.sv
// core_scheduler: per-core instruction sequencer.
// It steps a single core through fetch, decode, optional load/store,
// execute and PC update, then returns to fetch until a return is decoded.
//
// Ports:
//   clk, reset          rising-edge clock; synchronous active-high reset
//   start               level; launches execution from IDLE
//   fetch_req/addr/ack  program-memory read handshake (addr == pc)
//   fetch_data          fetched word, latched into instruction
//   instruction         latched instruction feeding the external decoder
//   dec_*               decoder controls (load, store, branch, return, target)
//   lsu_req/lsu_done    one-cycle load/store launch and its completion
//   exec_en             one-cycle ALU/register/NZP write strobe
//   pc, stage, done     program counter, encoded state, program finished
//   cycle_count         busy cycles (stage neither IDLE nor DONE)
//   instr_count         retired instructions (UPDATE cycles)
//
// Configuration macro: CORE_SCHEDULER_PERF_EN
//   defined   -> saturating 16-bit performance counters are built
//   undefined -> cycle_count / instr_count are tied to zero
module core_scheduler #(
  parameter int unsigned PC_BITS    = 8,
  parameter int unsigned INSTR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  fetch_req,
  output logic [PC_BITS-1:0]    fetch_addr,
  input  logic                  fetch_ack,
  input  logic [INSTR_BITS-1:0] fetch_data,
  output logic [INSTR_BITS-1:0] instruction,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  input  logic                  dec_next_address,
  input  logic                  dec_ret,
  input  logic [7:0]            dec_immediate,
  output logic                  lsu_req,
  input  logic                  lsu_done,
  output logic                  exec_en,
  output logic [PC_BITS-1:0]    pc,
  output logic [2:0]            stage,
  output logic                  done,
  output logic [15:0]           cycle_count,
  output logic [15:0]           instr_count
);

  localparam int unsigned CNT_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PC_BITS-1:0] pc_next;
  logic               mem_op_c;

  assign mem_op_c   = dec_mem_read | dec_mem_write;
  assign stage      = state;
  assign fetch_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-pc logic
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      S_IDLE:    if (start) state_next = S_FETCH;
      S_FETCH:   if (fetch_ack) state_next = S_DECODE;
      S_DECODE:  state_next = S_REQUEST;
      S_REQUEST: state_next = mem_op_c ? S_WAIT : S_EXECUTE;
      S_WAIT:    if (lsu_done) state_next = S_EXECUTE;
      S_EXECUTE: state_next = S_UPDATE;
      S_UPDATE: begin
        if (dec_ret) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FETCH;
          pc_next    = dec_next_address ? PC_BITS'(dec_immediate)
                                        : pc + PC_BITS'(1);
        end
      end
      S_DONE:    state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Registered datapath and strobes, decoded from the upcoming state so they
  // are aligned with stage. lsu_req is launched from DECODE so that it is
  // high exactly during the REQUEST cycle of a memory instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= '0;
      instruction <= '0;
      fetch_req   <= 1'b0;
      lsu_req     <= 1'b0;
      exec_en     <= 1'b0;
      done        <= 1'b0;
    end else begin
      pc <= pc_next;
      if (state == S_FETCH && fetch_ack) begin
        instruction <= fetch_data;
      end
      fetch_req <= (state_next == S_FETCH);
      lsu_req   <= (state == S_DECODE) && mem_op_c;
      exec_en   <= (state_next == S_EXECUTE);
      done      <= (state_next == S_DONE);
    end
  end

`ifdef CORE_SCHEDULER_PERF_EN
  logic [CNT_BITS-1:0] cycle_q;
  logic [CNT_BITS-1:0] instr_q;

  // Saturating busy-cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      if (state != S_IDLE && state != S_DONE && cycle_q != '1) begin
        cycle_q <= cycle_q + CNT_BITS'(1);
      end
      if (state == S_UPDATE && instr_q != '1) begin
        instr_q <= instr_q + CNT_BITS'(1);
      end
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 SHALL have parameter PC_BITS, 8, program counter and fetch address width.
REQ-002 SHALL have parameter INSTR_BITS, 16, instruction word width.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  level; launches execution from IDLE.
REQ-006 SHALL have port fetch_req  output  1  program-memory read request.
REQ-007 SHALL have port fetch_addr  output  PC_BITS  address of the fetch, equal to pc.
REQ-008 SHALL have port fetch_ack  input  1  program memory returns fetch_data this cycle.
REQ-009 SHALL have port fetch_data  input  INSTR_BITS  fetched instruction word.
REQ-010 SHALL have port instruction  output  INSTR_BITS  latched instruction driving the decoder.
REQ-011 SHALL have port dec_mem_read  input  1  decoded load control.
REQ-012 SHALL have port dec_mem_write  input  1  decoded store control.
REQ-013 SHALL have port dec_next_address  input  1  decoded branch-taken control.
REQ-014 SHALL have port dec_ret  input  1  decoded return control.
REQ-015 SHALL have port dec_immediate  input  8  branch target, low PC_BITS bits used.
REQ-016 SHALL have port lsu_req  output  1  one-cycle load/store launch pulse.
REQ-017 SHALL have port lsu_done  input  1  load/store completion.
REQ-018 SHALL have port exec_en  output  1  one-cycle ALU/register/NZP write strobe.
REQ-019 SHALL have port pc  output  PC_BITS  current program counter.
REQ-020 SHALL have port stage  output  3  encoded current state.
REQ-021 SHALL have port done  output  1  program finished.
REQ-022 SHALL have ports cycle_count, instr_count  output  16 each  performance counters.

Function
REQ-023 SHALL implement states IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7, driven on stage.
REQ-024 IDLE SHALL go to FETCH when start=1, else stay.
REQ-025 FETCH SHALL hold fetch_req=1 with fetch_addr=pc; on fetch_ack=1, latch fetch_data into instruction and go to DECODE; otherwise stay.
REQ-026 fetch_req SHALL be 0 in every state other than FETCH.
REQ-027 DECODE SHALL last exactly one cycle, then REQUEST.
REQ-028 REQUEST SHALL pulse lsu_req=1 for one cycle and go to WAIT when dec_mem_read or dec_mem_write is 1, else go directly to EXECUTE.
REQ-029 WAIT SHALL stay until lsu_done=1, then go to EXECUTE; lsu_done outside WAIT SHALL be ignored.
REQ-030 EXECUTE SHALL drive exec_en=1 for exactly one cycle, then UPDATE.
REQ-031 UPDATE with dec_ret=1 SHALL go to DONE and leave pc unchanged.
REQ-032 UPDATE with dec_ret=0 SHALL load pc with dec_immediate[PC_BITS-1:0] if dec_next_address=1, else pc+1 modulo 2^PC_BITS (wrap to 0), then go to FETCH.
REQ-033 DONE SHALL assert done=1 and hold until reset; start SHALL be ignored.
REQ-034 Non-memory instruction latency SHALL be 5 cycles FETCH-entry to next FETCH-entry when fetch_ack arrives in the first FETCH cycle.
REQ-035 instruction SHALL change only on a FETCH-state fetch_ack.

Reset
REQ-036 On reset=1 at a clock edge: state=IDLE, pc=0, instruction=0, done=0, fetch_req=0, lsu_req=0, exec_en=0, counters=0.
REQ-037 Reset SHALL take priority over every event, including mid-FETCH or mid-WAIT; pending fetch_ack/lsu_done in that cycle SHALL be discarded.

Configuration
REQ-038 Macro CORE_SCHEDULER_PERF_EN SHALL gate the performance counters.
REQ-039 With the macro defined: cycle_count increments every cycle stage is neither IDLE nor DONE; instr_count increments on each UPDATE cycle; both saturate at 0xFFFF.
REQ-040 Without the macro: cycle_count and instr_count SHALL be constant 0 and no counter registers exist.

Verification
REQ-041 reset, start=1, fetch_ack on first FETCH cycle with ADD word, no branch -> stage 1,2,3,5,6,1; exec_en one cycle; pc 0->1.
REQ-042 LDR with lsu_done 3 cycles after lsu_req -> lsu_req single pulse, WAIT held 3 cycles, exec_en once, pc+1.
REQ-043 dec_next_address=1, dec_immediate=0x2A in UPDATE -> pc=0x2A, fetch_addr=0x2A next FETCH.
REQ-044 pc=0xFF, non-branch instruction -> pc wraps to 0x00.
REQ-045 dec_ret=1 -> DONE, done=1 held, pc unchanged, start toggles ignored; with macro, instr_count equals instructions executed.
REQ-046 reset asserted in WAIT with lsu_done=1 same cycle -> IDLE, pc=0, done=0, exec_en never pulses.
